// File: rtl/rv32_mmio_arbiter.sv
// Two-requester round-robin arbiter onto a single MMIO target bus.
// Holds one request outstanding; completes on s_done or after TIMEOUT busy cycles.
module rv32_mmio_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [1:0]       m_valid_i,
  input  logic [1:0][31:0] m_addr_i,
  input  logic [1:0][31:0] m_wdata_i,
  input  logic [1:0]       m_we_i,
  output logic [1:0]       m_ready_o,
  output logic [1:0]       m_rvalid_o,
  output logic [1:0][31:0] m_rdata_o,
  output logic [1:0]       m_err_o,
  output logic             s_valid_o,
  output logic [31:0]      s_addr_o,
  output logic [31:0]      s_wdata_o,
  output logic             s_we_o,
  input  logic             s_done_i,
  input  logic [31:0]      s_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        grant;

  // Pointer only matters on contention; a lone requester always wins.
  always_comb begin
    if (&m_valid_i) grant = ptr_q;
    else            grant = m_valid_i[1];
  end

  // NOTE: every signal written here gets a default first so no latches are inferred.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    timer_d    = timer_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    s_valid_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|m_valid_i) begin
          m_ready_o[grant] = 1'b1;
          grant_d          = grant;
          addr_d           = m_addr_i[grant];
          wdata_d          = m_wdata_i[grant];
          we_d             = m_we_i[grant];
          timer_d          = '0;
          state_d          = S_BUSY;
        end
      end
      S_BUSY: begin
        s_valid_o = 1'b1;
        // A completion in the last allowed cycle beats the timeout.
        if (s_done_i) begin
          rdata_d = we_q ? 32'h0 : s_rdata_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RESP: begin
        m_rvalid_o[grant_q] = 1'b1;
        m_rdata_o[grant_q]  = rdata_q;
        m_err_o[grant_q]    = err_q;
        ptr_d               = ~grant_q;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet for the whole time reset is held.
    if (reset_i) begin
      m_ready_o  = '0;
      m_rvalid_o = '0;
      m_rdata_o  = '0;
      m_err_o    = '0;
      s_valid_o  = 1'b0;
    end
  end

  assign s_addr_o  = reset_i ? 32'h0 : addr_q;
  assign s_wdata_o = reset_i ? 32'h0 : wdata_q;
  assign s_we_o    = reset_i ? 1'b0  : we_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rv32_mmio_arbiter.sv
// Self-checking bench for rv32_mmio_arbiter: directed scenarios plus random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_rv32_mmio_arbiter;

  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [1:0]       m_valid;
  logic [1:0][31:0] m_addr;
  logic [1:0][31:0] m_wdata;
  logic [1:0]       m_we;
  logic [1:0]       m_ready;
  logic [1:0]       m_rvalid;
  logic [1:0][31:0] m_rdata;
  logic [1:0]       m_err;
  logic             s_valid;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdata;
  logic             s_we;
  logic             s_done;
  logic [31:0]      s_rdata;

  always #5 clk = ~clk;

  rv32_mmio_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .m_valid_i (m_valid),
    .m_addr_i  (m_addr),
    .m_wdata_i (m_wdata),
    .m_we_i    (m_we),
    .m_ready_o (m_ready),
    .m_rvalid_o(m_rvalid),
    .m_rdata_o (m_rdata),
    .m_err_o   (m_err),
    .s_valid_o (s_valid),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_we_o    (s_we),
    .s_done_i  (s_done),
    .s_rdata_i (s_rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;  // 0: drop request on grant, 1: keep requesting, 2: random traffic

  // Reference model: one outstanding transaction plus a pending response.
  bit          md_busy, md_resp, md_ptr, md_who, md_we;
  int          md_age;
  logic [31:0] md_addr, md_wdata;
  bit          md_resp_who, md_resp_err;
  logic [31:0] md_resp_data;

  // Observations taken from the DUT for the directed end-of-scenario checks.
  int          rv_cnt, sv_cnt, rv_cyc, rdy_cyc;
  bit          rv_who, rv_err;
  logic [31:0] rv_data;
  int          grants[$];
  int          grant_cycs[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    rv_cnt = 0; sv_cnt = 0; rv_cyc = -1; rdy_cyc = -1;
    rv_who = 0; rv_err = 0; rv_data = '0;
    grants.delete();
    grant_cycs.delete();
  endtask

  task automatic new_request(input int i);
    m_valid[i] = 1'b1;
    m_addr[i]  = $urandom;
    m_wdata[i] = $urandom;
    m_we[i]    = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: predict, compare at the falling edge, then advance.
  task automatic tick();
    logic [1:0]       e_ready, e_rvalid, e_err;
    logic [1:0][31:0] e_rdata;
    logic             e_sv;
    int               w;
    @(negedge clk);
    e_ready = '0; e_rvalid = '0; e_err = '0; e_rdata = '0; e_sv = 1'b0; w = -1;
    if (reset_i) begin
      md_busy = 0; md_resp = 0; md_ptr = 0;
      check("rst_s_addr",  s_addr,  64'h0);
      check("rst_s_wdata", s_wdata, 64'h0);
      check("rst_s_we",    s_we,    64'h0);
    end else if (md_resp) begin
      e_rvalid[md_resp_who] = 1'b1;
      e_rdata[md_resp_who]  = md_resp_data;
      e_err[md_resp_who]    = md_resp_err;
      md_ptr  = !md_resp_who;
      md_resp = 0;
    end else if (md_busy) begin
      e_sv = 1'b1;
      check("s_addr",  s_addr,  md_addr);
      check("s_wdata", s_wdata, md_wdata);
      check("s_we",    s_we,    md_we);
      if (s_done) begin
        md_resp = 1; md_resp_who = md_who; md_resp_err = 0;
        md_resp_data = md_we ? 32'h0 : s_rdata;
        md_busy = 0;
      end else if (md_age == TIMEOUT - 1) begin
        md_resp = 1; md_resp_who = md_who; md_resp_err = 1;
        md_resp_data = 32'h0;
        md_busy = 0;
      end else begin
        md_age++;
      end
    end else if (m_valid != 2'b00) begin
      if (m_valid == 2'b11) w = int'(md_ptr);
      else                  w = m_valid[1] ? 1 : 0;
      e_ready[w] = 1'b1;
      md_busy = 1; md_age = 0; md_who = w[0];
      md_addr = m_addr[w]; md_wdata = m_wdata[w]; md_we = m_we[w];
    end
    check("m_ready",  m_ready,  e_ready);
    check("m_rvalid", m_rvalid, e_rvalid);
    check("m_rdata",  m_rdata,  e_rdata);
    check("m_err",    m_err,    e_err);
    check("s_valid",  s_valid,  e_sv);

    if (s_valid === 1'b1) sv_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (m_ready[i] === 1'b1) begin
        rdy_cyc = cyc; grants.push_back(i); grant_cycs.push_back(cyc);
      end
      if (m_rvalid[i] === 1'b1) begin
        rv_cnt++; rv_cyc = cyc; rv_who = i[0]; rv_data = m_rdata[i]; rv_err = m_err[i];
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    if (w >= 0 && mode != 1) m_valid[w] = 1'b0;
    if (mode == 2) begin
      for (int i = 0; i < 2; i++)
        if (!m_valid[i] && $urandom_range(0, 2) == 0) new_request(i);
      s_done  = ($urandom_range(0, 7) == 0);
      s_rdata = $urandom;
      reset_i = ($urandom_range(0, 59) == 0);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1; m_valid = '0; s_done = 1'b0; mode = 0;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1; m_valid = '0; m_addr = '0; m_wdata = '0; m_we = '0;
    s_done = 1'b0; s_rdata = '0;
    clear_obs();
    tick();
    tick();

    // Single read with immediate completion; grant in the first cycle out of reset.
    do_reset();
    clear_obs();
    m_valid = 2'b01; m_addr[0] = 32'h1000_0004; m_we[0] = 1'b0; m_wdata[0] = 32'h0;
    tick();
    s_done = 1'b1; s_rdata = 32'hDEAD_BEEF;
    tick();
    s_done = 1'b0; s_rdata = 32'h0;
    tick();
    tick();
    check("r34_count",   rv_cnt,            1);
    check("r34_latency", rv_cyc - rdy_cyc,  2);
    check("r34_who",     rv_who,            0);
    check("r34_rdata",   rv_data,           64'hDEAD_BEEF);
    check("r34_err",     rv_err,            0);

    // Both requesters valid continuously: grants alternate every three cycles.
    do_reset();
    clear_obs();
    mode = 1; m_valid = 2'b11; m_we = 2'b00; s_done = 1'b1; s_rdata = 32'h5A5A_0001;
    repeat (12) tick();
    check("r35_ngrants", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      check($sformatf("r35_grant%0d", i), grants[i], i % 2);
      check($sformatf("r35_spacing%0d", i), grant_cycs[i] - grant_cycs[0], 3 * i);
    end

    // Write with no target response: timeout after exactly TIMEOUT busy cycles.
    do_reset();
    clear_obs();
    m_valid = 2'b10; m_addr[1] = 32'h2000_0000; m_wdata[1] = 32'h0000_00AA; m_we[1] = 1'b1;
    for (int i = 0; i < 40 && rv_cnt == 0; i++) tick();
    check("r36_completed", rv_cnt, 1);
    check("r36_svalid",    sv_cnt, 16);
    check("r36_who",       rv_who, 1);
    check("r36_err",       rv_err, 1);
    check("r36_rdata",     rv_data, 0);

    // Completion in the final busy cycle beats the timeout.
    do_reset();
    clear_obs();
    m_valid = 2'b01; m_addr[0] = 32'h3000_0010; m_we[0] = 1'b0;
    tick();
    repeat (TIMEOUT - 1) tick();
    s_done = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    s_done = 1'b0;
    tick();
    check("r37_completed", rv_cnt, 1);
    check("r37_err",       rv_err, 0);
    check("r37_rdata",     rv_data, 64'h1234_5678);
    check("r37_latency",   rv_cyc - rdy_cyc, TIMEOUT + 1);
    check("r37_svalid",    sv_cnt, TIMEOUT);

    // Reset during busy aborts the transaction and clears the pointer.
    do_reset();
    m_valid = 2'b01; m_addr[0] = 32'h4000_0000; m_we[0] = 1'b0;
    tick();
    s_done = 1'b1; s_rdata = 32'h0BAD_F00D;
    tick();
    s_done = 1'b0;
    tick();
    clear_obs();
    m_valid = 2'b10; m_addr[1] = 32'h4000_0100; m_we[1] = 1'b1; m_wdata[1] = 32'h77;
    tick();
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; m_valid = 2'b11; m_addr[0] = 32'h4000_0200;
    tick();
    check("r38_no_rvalid", rv_cnt, 0);
    check("r38_ngrants",   grants.size(), 2);
    if (grants.size() == 2) check("r38_regrant", grants[1], 0);
    m_valid = 2'b00; s_done = 1'b1;
    tick();
    tick();
    s_done = 1'b0;

    // Spurious s_done while idle changes nothing.
    do_reset();
    clear_obs();
    s_done = 1'b1;
    repeat (4) begin
      s_rdata = $urandom;
      tick();
    end
    s_done = 1'b0;
    check("r39_no_rvalid", rv_cnt, 0);
    check("r39_no_svalid", sv_cnt, 0);
    check("r39_no_grant",  grants.size(), 0);

    // Random traffic, including random resets and occasional timeouts.
    do_reset();
    mode = 2;
    repeat (3000) tick();
    mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
